// File: rtl/dcache_pkg.sv
// Shared geometry, address-field positions and controller state encoding
// for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int ADDR_W     = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES      = 1 << INDEX_W;
    localparam int LINE_BYTES = 1 << OFFSET_W;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_W;
    localparam int TAG_LSB    = OFFSET_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side bus of the data cache; the cache is the slave,
// the CPU/memory pair driving it is the master.
interface data_cache_if;
    import dcache_pkg::*;

    logic                  READ;
    logic                  WRITE;
    logic [ADDR_W-1:0]     ADDRESS;
    logic [7:0]            WRITEDATA;
    logic [7:0]            READDATA;
    logic                  BUSYWAIT;

    logic                  MEM_READ;
    logic                  MEM_WRITE;
    logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
    logic [LINE_W-1:0]     MEM_WRITEDATA;
    logic [LINE_W-1:0]     MEM_READDATA;
    logic                  MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

endinterface

// File: rtl/dcache_storage.sv
// Line storage: data/tag arrays (never reset) plus valid/dirty bits that
// clear asynchronously. One byte-write port, one line-refill port, async read.
module dcache_storage
    import dcache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [INDEX_W-1:0]  i_index,
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic                i_byte_we,
    input  logic [7:0]          i_byte_wdata,
    input  logic                i_fill_we,
    input  logic [TAG_W-1:0]    i_fill_tag,
    input  logic [LINE_W-1:0]   i_fill_data,
    input  logic                i_clean,
    output logic                o_valid,
    output logic                o_dirty,
    output logic [TAG_W-1:0]    o_tag,
    output logic [LINE_W-1:0]   o_line,
    output logic [7:0]          o_byte
);

    logic [LINES-1:0]           r_valid;
    logic [LINES-1:0]           r_dirty;
    logic [TAG_W-1:0]           r_tag  [LINES];
    logic [LINE_BYTES-1:0][7:0] r_data [LINES];

    // A refill always leaves the line clean, even if a byte write were pending.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_byte_we) begin
            r_dirty[i_index] <= 1'b1;
        end else if (i_clean) begin
            r_dirty[i_index] <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_fill_we) begin
            r_data[i_index] <= i_fill_data;
            r_tag[i_index]  <= i_fill_tag;
        end else if (i_byte_we) begin
            r_data[i_index][i_offset] <= i_byte_wdata;
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_line  = r_data[i_index];
    assign o_byte  = r_data[i_index][i_offset];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: hit detection and the
// IDLE/WRITEBACK/ALLOCATE miss controller around dcache_storage.
module data_cache
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    data_cache_if.slave bus
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_t                r_state;
    state_t                w_next_state;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_W-1:0]    w_index;
    logic [OFFSET_W-1:0]   w_offset;

    logic                  w_valid;
    logic                  w_dirty;
    logic [TAG_W-1:0]      w_line_tag;
    logic [LINE_W-1:0]     w_line;
    logic [7:0]            w_byte;

    logic                  w_hit;
    logic                  w_req;
    logic                  w_wr;
    logic                  w_idle_hit;
    logic                  w_byte_we;
    logic                  w_fill_we;
    logic                  w_clean;

    logic                  w_mem_read;
    logic                  w_mem_write;
    logic [MEM_ADDR_W-1:0] w_mem_addr;
    logic [LINE_W-1:0]     w_mem_wdata;

    assign w_tag    = bus.ADDRESS[ADDR_W-1 -: TAG_W];
    assign w_index  = bus.ADDRESS[OFFSET_W +: INDEX_W];
    assign w_offset = bus.ADDRESS[OFFSET_W-1:0];

    // READ takes priority when both strobes are high.
    assign w_req      = bus.READ | bus.WRITE;
    assign w_wr       = bus.WRITE & ~bus.READ;
    assign w_hit      = w_valid && (w_line_tag == w_tag);
    assign w_idle_hit = (r_state == IDLE) && w_hit;
    assign w_byte_we  = w_wr && w_idle_hit;

    dcache_storage u_storage (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_index      (w_index),
        .i_offset     (w_offset),
        .i_byte_we    (w_byte_we),
        .i_byte_wdata (bus.WRITEDATA),
        .i_fill_we    (w_fill_we),
        .i_fill_tag   (w_tag),
        .i_fill_data  (bus.MEM_READDATA),
        .i_clean      (w_clean),
        .o_valid      (w_valid),
        .o_dirty      (w_dirty),
        .o_tag        (w_line_tag),
        .o_line       (w_line),
        .o_byte       (w_byte)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Once a transfer starts it runs to completion even if the CPU drops its request.
    always_comb begin
        w_next_state = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_fill_we    = 1'b0;
        w_clean      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    w_next_state = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                w_mem_write = 1'b1;
                w_mem_addr  = {w_line_tag, w_index};
                w_mem_wdata = w_line;
                if (!bus.MEM_BUSYWAIT) begin
                    w_next_state = ALLOCATE;
                    w_clean      = 1'b1;
                end
            end
            ALLOCATE: begin
                w_mem_read = 1'b1;
                w_mem_addr = bus.ADDRESS[ADDR_W-1:OFFSET_W];
                if (!bus.MEM_BUSYWAIT) begin
                    w_next_state = IDLE;
                    w_fill_we    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // RESET gating keeps the CPU outputs quiet while reset is held with a request pending.
    assign bus.BUSYWAIT      = RESET && w_req && !w_idle_hit;
    assign bus.READDATA      = (RESET && bus.READ && w_idle_hit) ? w_byte : 8'h00;
    assign bus.MEM_READ      = w_mem_read;
    assign bus.MEM_WRITE     = w_mem_write;
    assign bus.MEM_ADDRESS   = w_mem_addr;
    assign bus.MEM_WRITEDATA = w_mem_wdata;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: hand-driven memory side, hand-computed expectations.
module tb_data_cache;

    logic CLK;
    logic RESET;
    int   n_chk;
    int   n_bad;

    data_cache_if bus ();

    data_cache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        RESET             = 1'b0;
        bus.READ          = 1'b0;
        bus.WRITE         = 1'b0;
        bus.ADDRESS       = 8'h00;
        bus.WRITEDATA     = 8'h00;
        bus.MEM_READDATA  = 32'h0;
        bus.MEM_BUSYWAIT  = 1'b1;
        tick();
        tick();

        // reset state
        chk("rst_busy",   {31'b0, bus.BUSYWAIT},  32'h0);
        chk("rst_mrd",    {31'b0, bus.MEM_READ},  32'h0);
        chk("rst_mwr",    {31'b0, bus.MEM_WRITE}, 32'h0);
        chk("rst_rdata",  {24'b0, bus.READDATA},  32'h0);
        chk("rst_maddr",  {26'b0, bus.MEM_ADDRESS}, 32'h0);
        chk("rst_mwdata", bus.MEM_WRITEDATA,      32'h0);
        RESET = 1'b1;

        // cold read miss at 0x00
        bus.READ = 1'b1;
        bus.ADDRESS = 8'h00;
        #1;
        chk("miss0_busy", {31'b0, bus.BUSYWAIT}, 32'h1);
        chk("miss0_idle_mrd", {31'b0, bus.MEM_READ}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("alloc0_mrd",   {31'b0, bus.MEM_READ},    32'h1);
            chk("alloc0_maddr", {26'b0, bus.MEM_ADDRESS}, 32'h00);
            chk("alloc0_busy",  {31'b0, bus.BUSYWAIT},    32'h1);
        end
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = 32'hDDCCBBAA;
        tick();
        chk("fill0_rdata", {24'b0, bus.READDATA}, 32'hAA);
        chk("fill0_busy",  {31'b0, bus.BUSYWAIT}, 32'h0);
        chk("fill0_mrd",   {31'b0, bus.MEM_READ}, 32'h0);
        bus.MEM_BUSYWAIT = 1'b1;
        tick();
        bus.ADDRESS = 8'h03;
        #1;
        chk("hit3_rdata", {24'b0, bus.READDATA}, 32'hDD);
        chk("hit3_busy",  {31'b0, bus.BUSYWAIT}, 32'h0);
        chk("hit3_mrd",   {31'b0, bus.MEM_READ}, 32'h0);

        // write hit at 0x01, read back
        tick();
        bus.READ = 1'b0;
        bus.WRITE = 1'b1;
        bus.ADDRESS = 8'h01;
        bus.WRITEDATA = 8'h55;
        #1;
        chk("whit_busy", {31'b0, bus.BUSYWAIT},  32'h0);
        chk("whit_mwr",  {31'b0, bus.MEM_WRITE}, 32'h0);
        chk("whit_rdata",{24'b0, bus.READDATA},  32'h0);
        tick();
        bus.WRITE = 1'b0;
        bus.READ = 1'b1;
        #1;
        chk("rback1", {24'b0, bus.READDATA}, 32'h55);

        // dirty conflict miss at 0x21 (index 0, tag 1)
        tick();
        bus.ADDRESS = 8'h21;
        #1;
        chk("miss21_busy", {31'b0, bus.BUSYWAIT}, 32'h1);
        tick();
        chk("wb0_mwr",    {31'b0, bus.MEM_WRITE},   32'h1);
        chk("wb0_mrd",    {31'b0, bus.MEM_READ},    32'h0);
        chk("wb0_maddr",  {26'b0, bus.MEM_ADDRESS}, 32'h00);
        chk("wb0_mwdata", bus.MEM_WRITEDATA,        32'hDDCC55AA);
        bus.MEM_BUSYWAIT = 1'b0;
        tick();
        chk("al21_mrd",   {31'b0, bus.MEM_READ},    32'h1);
        chk("al21_mwr",   {31'b0, bus.MEM_WRITE},   32'h0);
        chk("al21_maddr", {26'b0, bus.MEM_ADDRESS}, 32'h08);
        bus.MEM_READDATA = 32'h44332211;
        tick();
        chk("fill21_rdata", {24'b0, bus.READDATA}, 32'h22);
        chk("fill21_busy",  {31'b0, bus.BUSYWAIT}, 32'h0);
        bus.MEM_BUSYWAIT = 1'b1;
        tick();

        // write miss at 0x46 into invalid line 1
        bus.READ = 1'b0;
        bus.WRITE = 1'b1;
        bus.ADDRESS = 8'h46;
        bus.WRITEDATA = 8'h77;
        #1;
        chk("wmiss_busy", {31'b0, bus.BUSYWAIT}, 32'h1);
        tick();
        chk("al46_mrd",   {31'b0, bus.MEM_READ},    32'h1);
        chk("al46_maddr", {26'b0, bus.MEM_ADDRESS}, 32'h11);
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = 32'h0D0C0B0A;
        tick();
        chk("w46_busy", {31'b0, bus.BUSYWAIT},  32'h0);
        chk("w46_mwr",  {31'b0, bus.MEM_WRITE}, 32'h0);
        bus.MEM_BUSYWAIT = 1'b1;
        tick();
        bus.WRITE = 1'b0;
        bus.READ = 1'b1;
        #1;
        chk("rback46", {24'b0, bus.READDATA}, 32'h77);

        // read 0x66 evicts dirty line 1
        tick();
        bus.ADDRESS = 8'h66;
        tick();
        chk("wb1_mwr",    {31'b0, bus.MEM_WRITE},      32'h1);
        chk("wb1_maddr",  {26'b0, bus.MEM_ADDRESS},    32'h11);
        chk("wb1_mwdata", bus.MEM_WRITEDATA,           32'h0D770B0A);
        chk("wb1_byte2",  {24'b0, bus.MEM_WRITEDATA[23:16]}, 32'h77);
        bus.MEM_BUSYWAIT = 1'b0;
        tick();
        bus.MEM_BUSYWAIT = 1'b1;

        // memory stalls five cycles in ALLOCATE
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_busy",  {31'b0, bus.BUSYWAIT},    32'h1);
            chk("stall_mrd",   {31'b0, bus.MEM_READ},    32'h1);
            chk("stall_mwr",   {31'b0, bus.MEM_WRITE},   32'h0);
            chk("stall_maddr", {26'b0, bus.MEM_ADDRESS}, 32'h19);
        end
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = 32'h99887766;
        tick();
        chk("fill66_rdata", {24'b0, bus.READDATA}, 32'h88);
        chk("fill66_busy",  {31'b0, bus.BUSYWAIT}, 32'h0);
        bus.MEM_BUSYWAIT = 1'b1;
        tick();

        // reset asserted mid-ALLOCATE at 0x80
        bus.ADDRESS = 8'h80;
        tick();
        chk("al80_mrd", {31'b0, bus.MEM_READ}, 32'h1);
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_mrd",  {31'b0, bus.MEM_READ}, 32'h0);
        chk("arst_busy", {31'b0, bus.BUSYWAIT}, 32'h0);
        #1;
        RESET = 1'b1;
        #1;
        chk("post_rst_busy", {31'b0, bus.BUSYWAIT}, 32'h1);
        tick();
        chk("post_rst_mrd",   {31'b0, bus.MEM_READ},    32'h1);
        chk("post_rst_maddr", {26'b0, bus.MEM_ADDRESS}, 32'h20);

        bus.READ = 1'b0;
        bus.MEM_BUSYWAIT = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
